// File: rtl/collatz_wb_ctrl.sv
// Wishbone classic slave that sequences an external Collatz iteration core.
// Software writes a seed, requests a start, and reads back the final value,
// the iteration count and the peak value reached during the run.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   wbs_cyc_i/stb_i/we_i  Wishbone classic slave controls
//   wbs_sel_i[3:0]        byte lanes (lanes 0/1 honoured on SEED, lane 0 on CTRL)
//   wbs_adr_i[31:0]       address, only [3:2] decoded
//   wbs_dat_i/o[31:0]     write / registered read data
//   wbs_ack_o             single-cycle acknowledge
//   irq                   level interrupt, done AND irq_en (registered)
//   co[15:0], st          seed and one-cycle start pulse to the core
//   x[15:0], bs           core current value and busy flag
//
// Register map (adr[3:2]):
//   0 CTRL/STATUS  wr: b0 start, b1 clear done/err, b2 irq_en
//                  rd: b0 busy, b1 done, b2 irq_en, b3 err, b4 sat
//   1 SEED         [15:0] RW
//   2 RESULT       [15:0] final x, [31:16] step count (RO)
//   3 MAX          [15:0] peak x (RO)
module collatz_wb_ctrl #(
  parameter int START_TO = 4,
  parameter int STEP_W   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o,
  output logic        irq,
  output logic [15:0] co,
  output logic        st,
  input  logic [15:0] x,
  input  logic        bs
);

  typedef enum logic [1:0] {IDLE, START, WAIT, RUN} state_t;

  localparam logic [15:0] TO_LAST = 16'(START_TO - 1);

  state_t            state;
  state_t            state_nxt;
  logic              st_nxt;
  logic              busy;

  logic [15:0]       seed;
  logic [15:0]       result_x;
  logic [15:0]       max_x;
  logic [STEP_W-1:0] steps;
  logic [15:0]       steps16;
  logic [15:0]       to_cnt;
  logic              done;
  logic              err;
  logic              sat;
  logic              irq_en;

  logic              req;
  logic              wr;
  logic              rd;
  logic [1:0]        reg_sel;
  logic              wr_ctrl;
  logic              start_req;
  logic              clr_req;
  logic              wr_seed;
  logic              timeout;
  logic [STEP_W:0]   inc_r;
  logic [31:0]       rd_data;
  logic              unused_bits;

  // Saturating step increment; MSB of the result flags an attempted wrap.
  function automatic logic [STEP_W:0] sat_inc(input logic [STEP_W-1:0] v);
    if (&v) return {1'b1, v};
    return {1'b0, v + STEP_W'(1)};
  endfunction

  // A request is accepted only while ack is low, so acks never run back to back.
  assign req       = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
  assign wr        = req & wbs_we_i;
  assign rd        = req & ~wbs_we_i;
  assign reg_sel   = wbs_adr_i[3:2];
  assign wr_ctrl   = wr & (reg_sel == 2'd0) & wbs_sel_i[0];
  assign start_req = wr_ctrl & wbs_dat_i[0];
  assign clr_req   = wr_ctrl & wbs_dat_i[1];
  assign wr_seed   = wr & (reg_sel == 2'd1) & ~busy;
  assign timeout   = (to_cnt == TO_LAST);
  assign inc_r     = sat_inc(steps);
  assign steps16   = 16'(steps);
  assign co        = seed;
  assign unused_bits = ^{wbs_adr_i[31:4], wbs_adr_i[1:0], wbs_dat_i[31:16], wbs_sel_i[3:2]};

  // FSM state register; st is registered from the next state so it is
  // high exactly while the FSM sits in START.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      st    <= 1'b0;
    end else begin
      state <= state_nxt;
      st    <= st_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (start_req && (seed != 16'd0)) state_nxt = START;
      START: state_nxt = WAIT;
      WAIT:  begin
        if (bs)           state_nxt = RUN;
        else if (timeout) state_nxt = IDLE;
      end
      RUN:   if (!bs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    st_nxt = (state_nxt == START);
    busy   = (state != IDLE);
  end

  // Read mux, captured into wbs_dat_o on the accepting cycle.
  always_comb begin
    rd_data = 32'd0;
    unique case (reg_sel)
      2'd0: rd_data = {27'd0, sat, err, irq_en, done, busy};
      2'd1: rd_data = {16'd0, seed};
      2'd2: rd_data = {steps16, result_x};
      2'd3: rd_data = {16'd0, max_x};
      default: rd_data = 32'd0;
    endcase
  end

  // Bus response, registers and run bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= 32'd0;
      irq       <= 1'b0;
      seed      <= 16'd0;
      result_x  <= 16'd0;
      max_x     <= 16'd0;
      steps     <= '0;
      to_cnt    <= 16'd0;
      done      <= 1'b0;
      err       <= 1'b0;
      sat       <= 1'b0;
      irq_en    <= 1'b0;
    end else begin
      wbs_ack_o <= req;
      irq       <= done & irq_en;
      if (rd) wbs_dat_o <= rd_data;
      if (wr_ctrl) irq_en <= wbs_dat_i[2];
      if (wr_seed && wbs_sel_i[0]) seed[7:0]  <= wbs_dat_i[7:0];
      if (wr_seed && wbs_sel_i[1]) seed[15:8] <= wbs_dat_i[15:8];

      // Clear comes first so a combined clear+start still launches, and a
      // completion landing in the same cycle still sets its flag.
      if (clr_req) begin
        done <= 1'b0;
        err  <= 1'b0;
      end

      unique case (state)
        IDLE: begin
          if (start_req) begin
            if (seed != 16'd0) begin
              done  <= 1'b0;
              err   <= 1'b0;
              sat   <= 1'b0;
              steps <= '0;
              max_x <= seed;
            end else begin
              err <= 1'b1;
            end
          end
        end
        START: to_cnt <= 16'd0;
        WAIT: begin
          to_cnt <= to_cnt + 16'd1;
          if (bs) begin
            // The cycle bs first rises is iteration 1.
            steps <= STEP_W'(1);
            if (x > max_x) max_x <= x;
          end else if (timeout) begin
            err <= 1'b1;
          end
        end
        RUN: begin
          if (bs) begin
            steps <= inc_r[STEP_W-1:0];
            if (inc_r[STEP_W]) sat <= 1'b1;
            if (x > max_x) max_x <= x;
          end else begin
            result_x <= x;
            done     <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_collatz_wb_ctrl.sv
// Bench for collatz_wb_ctrl: a behavioural Collatz core drives x/bs, a
// second instance with a 4-bit step counter exercises saturation in lockstep.
module tb_collatz_wb_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] wdat;
  logic [31:0] dat_o;
  logic [31:0] dat2_o;
  logic        ack;
  logic        ack2;
  logic        irq;
  logic        irq2;
  logic [15:0] co;
  logic [15:0] co2;
  logic        st;
  logic        st2;
  logic [15:0] x = 16'd0;
  logic        bs = 1'b0;
  logic        core_dead = 1'b0;

  int checks = 0;
  int errors = 0;
  int st_cnt = 0;

  collatz_wb_ctrl #(.START_TO(4), .STEP_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_dat_o(dat_o), .wbs_ack_o(ack),
    .irq(irq), .co(co), .st(st), .x(x), .bs(bs)
  );

  collatz_wb_ctrl #(.START_TO(4), .STEP_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_dat_o(dat2_o), .wbs_ack_o(ack2),
    .irq(irq2), .co(co2), .st(st2), .x(x), .bs(bs)
  );

  function automatic logic [15:0] cnext(input logic [15:0] v);
    if (v[0]) return 16'(32'(v) * 3 + 1);
    return v >> 1;
  endfunction

  // Core model: loads the seed on st, then one iteration per clock until x==1.
  always @(posedge clk) begin
    if (st && !core_dead) begin
      x  <= co;
      bs <= (co > 16'd1);
    end else if (bs) begin
      x  <= cnext(x);
      bs <= (cnext(x) != 16'd1);
    end
  end

  always @(posedge clk) if (st) st_cnt <= st_cnt + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic wb_xfer(input logic w, input logic [1:0] a, input logic [31:0] d,
                         input logic [3:0] s, output logic [31:0] r, output logic [31:0] r2);
    int n;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = {28'h0, a, 2'b00}; wdat = d; sel = s;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!ack && n < 8);
    r  = dat_o;
    r2 = dat2_o;
    if (!ack) begin
      checks++; errors++;
      $display("FAIL ack_timeout actual=0 required=1");
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wb_wr(input logic [1:0] a, input logic [31:0] d);
    logic [31:0] r, r2;
    wb_xfer(1'b1, a, d, 4'hF, r, r2);
  endtask

  task automatic wb_rd_chk(input string nm, input logic [1:0] a, input logic [31:0] e);
    logic [31:0] r, r2;
    wb_xfer(1'b0, a, 32'd0, 4'hF, r, r2);
    chk(nm, r, e);
  endtask

  task automatic wait_idle();
    logic [31:0] r, r2;
    int n;
    n = 0;
    do begin
      wb_xfer(1'b0, 2'd0, 32'd0, 4'hF, r, r2);
      n++;
    end while (r[0] && n < 400);
    if (r[0]) begin
      checks++; errors++;
      $display("FAIL wait_idle actual=busy required=idle");
    end
  endtask

  localparam int OP_WR = 0;
  localparam int OP_RD = 1;
  localparam int OP_WT = 2;
  localparam int OP_IQ = 3;

  typedef struct {
    int          op;
    logic [1:0]  a;
    logic [31:0] d;
    logic [3:0]  s;
    logic [31:0] e;
    logic [31:0] e2;
    string       nm;
  } vec_t;

  function automatic vec_t mk(int op, logic [1:0] a, logic [31:0] d, logic [3:0] s,
                              logic [31:0] e, logic [31:0] e2, string nm);
    vec_t v;
    v.op = op; v.a = a; v.d = d; v.s = s; v.e = e; v.e2 = e2; v.nm = nm;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    logic [31:0] r, r2;
    int st0, nack, n;
    int pat[3] = '{1, 0, 1};

    // Register access, seed 6 run, seed 27 run with irq, byte lanes.
    tbl.push_back(mk(OP_RD, 2'd0, 0, 4'hF, 32'h0, 32'h0, "rst_ctrl"));
    tbl.push_back(mk(OP_RD, 2'd1, 0, 4'hF, 32'h0, 32'h0, "rst_seed"));
    tbl.push_back(mk(OP_RD, 2'd2, 0, 4'hF, 32'h0, 32'h0, "rst_result"));
    tbl.push_back(mk(OP_RD, 2'd3, 0, 4'hF, 32'h0, 32'h0, "rst_max"));
    tbl.push_back(mk(OP_WR, 2'd1, 32'hFFFF_0006, 4'hF, 0, 0, "wr_seed"));
    tbl.push_back(mk(OP_RD, 2'd1, 0, 4'hF, 32'h6, 32'h6, "seed_rw"));
    tbl.push_back(mk(OP_WR, 2'd2, 32'hDEAD_BEEF, 4'hF, 0, 0, "wr_result"));
    tbl.push_back(mk(OP_WR, 2'd3, 32'h1234_5678, 4'hF, 0, 0, "wr_max"));
    tbl.push_back(mk(OP_RD, 2'd2, 0, 4'hF, 32'h0, 32'h0, "result_ro"));
    tbl.push_back(mk(OP_RD, 2'd3, 0, 4'hF, 32'h0, 32'h0, "max_ro"));
    tbl.push_back(mk(OP_WR, 2'd0, 32'h1, 4'hF, 0, 0, "start6"));
    tbl.push_back(mk(OP_WT, 2'd0, 0, 4'hF, 0, 0, "wait6"));
    tbl.push_back(mk(OP_RD, 2'd0, 0, 4'hF, 32'h2, 32'h2, "s6_ctrl"));
    tbl.push_back(mk(OP_RD, 2'd2, 0, 4'hF, 32'h0008_0001, 32'h0008_0001, "s6_result"));
    tbl.push_back(mk(OP_RD, 2'd3, 0, 4'hF, 32'd16, 32'd16, "s6_max"));
    tbl.push_back(mk(OP_IQ, 2'd0, 0, 4'hF, 32'h0, 32'h0, "s6_irq"));
    tbl.push_back(mk(OP_WR, 2'd1, 32'd27, 4'hF, 0, 0, "wr_seed27"));
    tbl.push_back(mk(OP_WR, 2'd0, 32'h4, 4'hF, 0, 0, "wr_irq_en"));
    tbl.push_back(mk(OP_RD, 2'd0, 0, 4'hF, 32'h6, 32'h6, "irq_en_set"));
    tbl.push_back(mk(OP_IQ, 2'd0, 0, 4'hF, 32'h1, 32'h1, "irq_done_en"));
    tbl.push_back(mk(OP_WR, 2'd0, 32'h5, 4'hF, 0, 0, "start27"));
    tbl.push_back(mk(OP_WT, 2'd0, 0, 4'hF, 0, 0, "wait27"));
    tbl.push_back(mk(OP_RD, 2'd0, 0, 4'hF, 32'h6, 32'h16, "s27_ctrl"));
    tbl.push_back(mk(OP_RD, 2'd2, 0, 4'hF, 32'h006F_0001, 32'h000F_0001, "s27_result"));
    tbl.push_back(mk(OP_RD, 2'd3, 0, 4'hF, 32'd9232, 32'd9232, "s27_max"));
    tbl.push_back(mk(OP_IQ, 2'd0, 0, 4'hF, 32'h1, 32'h1, "s27_irq"));
    tbl.push_back(mk(OP_WR, 2'd0, 32'h6, 4'hF, 0, 0, "clear"));
    tbl.push_back(mk(OP_RD, 2'd0, 0, 4'hF, 32'h4, 32'h14, "clr_ctrl"));
    tbl.push_back(mk(OP_IQ, 2'd0, 0, 4'hF, 32'h0, 32'h0, "clr_irq"));
    tbl.push_back(mk(OP_WR, 2'd1, 32'h0000_AB99, 4'b0010, 0, 0, "seed_lane1"));
    tbl.push_back(mk(OP_RD, 2'd1, 0, 4'hF, 32'hAB1B, 32'hAB1B, "seed_lane1_rd"));
    tbl.push_back(mk(OP_WR, 2'd1, 32'h0000_FF06, 4'b0001, 0, 0, "seed_lane0"));
    tbl.push_back(mk(OP_RD, 2'd1, 0, 4'hF, 32'hAB06, 32'hAB06, "seed_lane0_rd"));

    rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; adr = 32'd0; wdat = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outs", {29'd0, st, ack, irq}, 32'h0);
    chk("rst_dat", dat_o, 32'h0);
    chk("rst_co", {16'd0, co}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      case (tbl[i].op)
        OP_WR: wb_xfer(1'b1, tbl[i].a, tbl[i].d, tbl[i].s, r, r2);
        OP_RD: begin
          wb_xfer(1'b0, tbl[i].a, 32'd0, tbl[i].s, r, r2);
          chk(tbl[i].nm, r, tbl[i].e);
          chk({tbl[i].nm, "_sat"}, r2, tbl[i].e2);
        end
        OP_WT: wait_idle();
        default: begin
          chk(tbl[i].nm, {31'd0, irq}, tbl[i].e);
          chk({tbl[i].nm, "_sat"}, {31'd0, irq2}, tbl[i].e2);
        end
      endcase
    end

    // Zero seed: error, no start pulse, single ack.
    wb_wr(2'd0, 32'h2);
    wb_wr(2'd1, 32'h0);
    st0 = st_cnt;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'd0; wdat = 32'h1; sel = 4'hF;
    nack = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (ack) begin
        nack++;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    chk("s0_ack_cnt", nack, 1);
    chk("s0_st_cnt", st_cnt - st0, 0);
    wb_rd_chk("s0_ctrl", 2'd0, 32'h8);

    // Core never answers: timeout after START_TO cycles in WAIT.
    core_dead = 1'b1;
    wb_wr(2'd1, 32'd5);
    st0 = st_cnt;
    wb_wr(2'd0, 32'h3);
    wb_rd_chk("to_busy", 2'd0, 32'h1);
    repeat (8) @(posedge clk);
    wb_rd_chk("to_err", 2'd0, 32'h8);
    chk("to_st_cnt", st_cnt - st0, 1);
    core_dead = 1'b0;

    // Reset mid-run: everything clears at once; the still-busy core is ignored.
    wb_wr(2'd1, 32'd27);
    wb_wr(2'd0, 32'h3);
    repeat (45) @(posedge clk);
    wb_rd_chk("run_busy", 2'd0, 32'h1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_outs", {29'd0, st, ack, irq}, 32'h0);
    chk("arst_dat", dat_o, 32'h0);
    chk("arst_co", {16'd0, co}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    wb_rd_chk("post_rst_ctrl", 2'd0, 32'h0);
    wb_rd_chk("post_rst_result", 2'd2, 32'h0);
    wb_rd_chk("post_rst_max", 2'd3, 32'h0);
    n = 0;
    while (bs && n < 300) begin
      @(posedge clk); n++;
    end
    wb_wr(2'd1, 32'd6);
    st0 = st_cnt;
    wb_wr(2'd0, 32'h1);
    wait_idle();
    chk("rerun_st_cnt", st_cnt - st0, 1);
    wb_rd_chk("rerun_result", 2'd2, 32'h0008_0001);
    wb_rd_chk("rerun_max", 2'd3, 32'd16);

    // SEED write while busy is dropped; back-to-back request acks 1,0,1.
    wb_wr(2'd0, 32'h1);
    wb_wr(2'd1, 32'h1234);
    wb_rd_chk("busy_ctrl", 2'd0, 32'h1);
    repeat (2) @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h4; sel = 4'hF;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk($sformatf("b2b_ack%0d", i), {31'd0, ack}, pat[i]);
      if (ack) chk($sformatf("b2b_dat%0d", i), dat_o, 32'h6);
    end
    cyc = 1'b0; stb = 1'b0;
    wait_idle();
    wb_rd_chk("seedlock_result", 2'd2, 32'h0008_0001);
    wb_rd_chk("seedlock_seed", 2'd1, 32'h6);
    wb_rd_chk("seedlock_ctrl", 2'd0, 32'h2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
